// File: rtl/rv32_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: opcodes, FSM states,
// PC and writeback mux selects.
package rv32_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  localparam logic [1:0] PC_SEL_PLUS4 = 2'd0;
  localparam logic [1:0] PC_SEL_IMM   = 2'd1;
  localparam logic [1:0] PC_SEL_JALR  = 2'd2;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_IMM  = 2'd3;

  // x1 (ra) and x5 (t0) are the link registers for return-address prediction
  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/rv32_multicycle_ctrl_if.sv
// Instruction and data memory request/ready handshakes between the controller
// (master) and the memory subsystem (slave).
interface rv32_multicycle_ctrl_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/rv32_mem_timer.sv
// Memory wait timer: down-counter reloaded on every FSM state change, decremented
// while a request waits; expired flags the last permitted wait cycle.
module rv32_mem_timer #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic count,
  output logic expired
);

  localparam int TW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int LOAD_VAL = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= TW'(LOAD_VAL);
    end else if (count && (cnt != '0)) begin
      cnt <= cnt - TW'(1);
    end
  end

  // MEM_TIMEOUT of zero disables expiry, so a request may wait forever
  assign expired = (MEM_TIMEOUT != 0) && count && (cnt == '0);

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// drives memory handshakes, PC update, RAS hints and the retired-instruction count.
//
//  state  | meaning
//  IDLE   | post-reset, one cycle, then fetch
//  FETCH  | imem_req held until imem_ready; latch IR
//  DECODE | decoder settles, no outputs
//  EXEC   | ALU operand select, branch resolve, RAS hints, illegal trap
//  MEM    | dmem_req held until dmem_ready (load or store)
//  WB     | register write, PC update, retire
module rv32_multicycle_ctrl
  import rv32_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  rv32_multicycle_ctrl_if.master        mem,
  input  logic [6:0]                    opcode,
  input  logic [2:0]                    funct3,
  input  logic [4:0]                    rd,
  input  logic [4:0]                    rs1,
  input  logic                          br_taken,
  output logic                          ir_we,
  output logic                          pc_we,
  output logic [1:0]                    pc_sel,
  output logic                          alu_a_sel,
  output logic                          alu_b_sel,
  output logic                          rf_we,
  output logic [1:0]                    wb_sel,
  output logic                          ras_push,
  output logic                          ras_pop,
  output logic                          illegal,
  output logic                          bus_err,
  output logic [31:0]                   instret
);

  state_t state, state_nxt;
  logic   retire;
  logic   tmr_load, tmr_count, tmr_expired;
  logic   is_store, is_op, is_branch, is_jal, is_jalr, is_auipc;
  logic   rd_link, rs1_link;

  // funct3 is consumed by the datapath decoders; sequencing does not depend on it
  logic unused_funct3;
  assign unused_funct3 = ^funct3;

  assign is_store  = (opcode == OPC_STORE);
  assign is_op     = (opcode == OPC_OP);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jal    = (opcode == OPC_JAL);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign rd_link   = is_link(rd);
  assign rs1_link  = is_link(rs1);

  assign tmr_count = ((state == ST_FETCH) && !mem.imem_ready) ||
                     ((state == ST_MEM)   && !mem.dmem_ready);
  assign tmr_load  = (state_nxt != state) || tmr_expired;

  rv32_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (tmr_load),
    .count   (tmr_count),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    mem.imem_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we  = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = PC_SEL_PLUS4;
    alu_a_sel    = 1'b0;
    alu_b_sel    = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = WB_SEL_ALU;
    ras_push     = 1'b0;
    ras_pop      = 1'b0;
    illegal      = 1'b0;
    bus_err      = 1'b0;
    retire       = 1'b0;
    case (state)
      ST_IDLE: state_nxt = ST_FETCH;
      ST_FETCH: begin
        mem.imem_req = 1'b1;
        // ir_we follows imem_ready in the same cycle so the IR captures the returned word
        if (mem.imem_ready) begin
          ir_we     = 1'b1;
          state_nxt = ST_DECODE;
        end else if (tmr_expired) begin
          bus_err = 1'b1;
        end
      end
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        alu_a_sel = is_auipc || is_jal;
        alu_b_sel = !(is_op || is_branch);
        if (is_jal || is_jalr) begin
          ras_push = rd_link;
        end
        if (is_jalr) begin
          ras_pop = rs1_link && (!rd_link || (rd != rs1));
        end
        case (opcode)
          OPC_LOAD, OPC_STORE: state_nxt = ST_MEM;
          OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: state_nxt = ST_WB;
          OPC_BRANCH: begin
            pc_we     = 1'b1;
            pc_sel    = br_taken ? PC_SEL_IMM : PC_SEL_PLUS4;
            retire    = 1'b1;
            state_nxt = ST_FETCH;
          end
          default: begin
            illegal   = 1'b1;
            pc_we     = 1'b1;
            retire    = 1'b1;
            state_nxt = ST_FETCH;
          end
        endcase
      end
      ST_MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we  = is_store;
        if (mem.dmem_ready) begin
          if (is_store) begin
            pc_we     = 1'b1;
            retire    = 1'b1;
            state_nxt = ST_FETCH;
          end else begin
            state_nxt = ST_WB;
          end
        end else if (tmr_expired) begin
          // abandon the access and skip the instruction without retiring it
          bus_err   = 1'b1;
          pc_we     = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_WB: begin
        rf_we     = (rd != 5'd0);
        pc_we     = 1'b1;
        retire    = 1'b1;
        state_nxt = ST_FETCH;
        case (opcode)
          OPC_LOAD:          wb_sel = WB_SEL_LOAD;
          OPC_JAL, OPC_JALR: wb_sel = WB_SEL_PC4;
          OPC_LUI:           wb_sel = WB_SEL_IMM;
          default:           wb_sel = WB_SEL_ALU;
        endcase
        if (is_jal) begin
          pc_sel = PC_SEL_IMM;
        end else if (is_jalr) begin
          pc_sel = PC_SEL_JALR;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= 32'd0;
    end else if (retire) begin
      instret <= instret + 32'd1;
    end
  end

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Directed bench for rv32_multicycle_ctrl: expected per-instruction outcomes are queued
// at issue and compared when the controller updates the PC or reports a bus error.
module tb_rv32_multicycle_ctrl;

  typedef struct {
    string       tag;
    int          cyc;
    bit          pc_we;
    bit [1:0]    pc_sel;
    bit          rf_we;
    bit [1:0]    wb_sel;
    int          n_dmem;
    bit          dmem_we;
    int          n_push;
    int          n_pop;
    int          n_both;
    bit          ill;
    bit          berr;
    bit          a;
    bit          b;
    int          n_ir;
    logic [31:0] instret;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic        br_taken;
  logic        ir_we, pc_we, alu_a_sel, alu_b_sel, rf_we;
  logic        ras_push, ras_pop, illegal, bus_err;
  logic [1:0]  pc_sel, wb_sel;
  logic [31:0] instret;

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  int          dmem_delay = 0;
  int          dk = 0;
  logic [31:0] exp_instret = 0;
  exp_t        q[$];
  exp_t        cur;

  int m_cyc, m_ir, m_dmem, m_rf, m_push, m_pop, m_both, m_ill, m_berr;
  bit m_dwe, m_a, m_b, m_cnt;

  always #5 clk = ~clk;

  rv32_multicycle_ctrl_if mem_if ();

  rv32_multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem       (mem_if.master),
    .opcode    (opcode),
    .funct3    (funct3),
    .rd        (rd),
    .rs1       (rs1),
    .br_taken  (br_taken),
    .ir_we     (ir_we),
    .pc_we     (pc_we),
    .pc_sel    (pc_sel),
    .alu_a_sel (alu_a_sel),
    .alu_b_sel (alu_b_sel),
    .rf_we     (rf_we),
    .wb_sel    (wb_sel),
    .ras_push  (ras_push),
    .ras_pop   (ras_pop),
    .illegal   (illegal),
    .bus_err   (bus_err),
    .instret   (instret)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t dflt(input string tag, input int cyc);
    exp_t e;
    e.tag = tag;  e.cyc = cyc;  e.pc_we = 1'b1; e.pc_sel = 2'd0;
    e.rf_we = 1'b0; e.wb_sel = 2'd0; e.n_dmem = 0; e.dmem_we = 1'b0;
    e.n_push = 0; e.n_pop = 0; e.n_both = 0; e.ill = 1'b0; e.berr = 1'b0;
    e.a = 1'b0; e.b = 1'b0; e.n_ir = 1; e.instret = exp_instret;
    return e;
  endfunction

  task automatic set_instr(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                           input logic taken);
    opcode = op; rd = d; rs1 = s1; br_taken = taken;
  endtask

  task automatic run(input exp_t e, input bit retire);
    q.push_back(e);
    if (retire) exp_instret++;
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    check($sformatf("%s drained", e.tag), q.size(), 0);
    q.delete();
  endtask

  task automatic mon_clear();
    m_cyc = 0; m_ir = 0; m_dmem = 0; m_rf = 0; m_push = 0; m_pop = 0; m_both = 0;
    m_ill = 0; m_berr = 0; m_dwe = 0; m_a = 0; m_b = 0; m_cnt = 0;
  endtask

  // memory responder: dmem_ready rises after dmem_delay waiting cycles
  initial begin
    mem_if.dmem_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (mem_if.dmem_req) begin
        dk++;
        mem_if.dmem_ready = (dk > dmem_delay);
      end else begin
        dk = 0;
        mem_if.dmem_ready = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_clear();
    end else begin
      if (mem_if.imem_req) m_cnt = 1;
      if (m_cnt) begin
        m_cyc++;
        if (ir_we) m_ir++;
        if (mem_if.dmem_req) begin
          m_dmem++;
          if (mem_if.dmem_we) m_dwe = 1;
        end
        if (rf_we) m_rf++;
        if (ras_push) m_push++;
        if (ras_pop) m_pop++;
        if (ras_push && ras_pop) m_both++;
        if (illegal) m_ill++;
        if (bus_err) m_berr++;
        if (alu_a_sel) m_a = 1;
        if (alu_b_sel) m_b = 1;
      end
      if (pc_we || bus_err) begin
        check("sb pending", q.size() != 0, 1);
        if (q.size() != 0) begin
          cur = q.pop_front();
          check($sformatf("%s cycles", cur.tag), m_cyc, cur.cyc);
          check($sformatf("%s pc_we", cur.tag), pc_we, cur.pc_we);
          check($sformatf("%s pc_sel", cur.tag), pc_sel, cur.pc_sel);
          check($sformatf("%s rf_we", cur.tag), rf_we, cur.rf_we);
          check($sformatf("%s rf_we cycles", cur.tag), m_rf, cur.rf_we);
          check($sformatf("%s wb_sel", cur.tag), wb_sel, cur.wb_sel);
          check($sformatf("%s dmem_req cycles", cur.tag), m_dmem, cur.n_dmem);
          check($sformatf("%s dmem_we", cur.tag), m_dwe, cur.dmem_we);
          check($sformatf("%s ras_push", cur.tag), m_push, cur.n_push);
          check($sformatf("%s ras_pop", cur.tag), m_pop, cur.n_pop);
          check($sformatf("%s push+pop", cur.tag), m_both, cur.n_both);
          check($sformatf("%s illegal", cur.tag), m_ill, cur.ill);
          check($sformatf("%s bus_err", cur.tag), m_berr, cur.berr);
          check($sformatf("%s alu_a_sel", cur.tag), m_a, cur.a);
          check($sformatf("%s alu_b_sel", cur.tag), m_b, cur.b);
          check($sformatf("%s ir_we", cur.tag), m_ir, cur.n_ir);
          check($sformatf("%s instret", cur.tag), instret, cur.instret);
        end
        mon_clear();
      end
    end
  end

  initial begin
    exp_t e;
    rst_n = 1'b0;
    funct3 = 3'd0;
    set_instr(7'h00, 5'd0, 5'd0, 1'b0);
    mem_if.imem_ready = 1'b1;
    #12;
    check("rst imem_req", mem_if.imem_req, 0);
    check("rst dmem_req", mem_if.dmem_req, 0);
    check("rst dmem_we", mem_if.dmem_we, 0);
    check("rst ir_we", ir_we, 0);
    check("rst pc_we", pc_we, 0);
    check("rst pc_sel", pc_sel, 0);
    check("rst alu_a_sel", alu_a_sel, 0);
    check("rst alu_b_sel", alu_b_sel, 0);
    check("rst rf_we", rf_we, 0);
    check("rst wb_sel", wb_sel, 0);
    check("rst ras_push", ras_push, 0);
    check("rst ras_pop", ras_pop, 0);
    check("rst illegal", illegal, 0);
    check("rst bus_err", bus_err, 0);
    check("rst instret", instret, 0);

    @(posedge clk); #1;
    set_instr(7'h13, 5'd1, 5'd0, 1'b0);
    rst_n = 1'b1;
    e = dflt("addi x1", 4); e.rf_we = 1; e.b = 1; run(e, 1);

    funct3 = 3'b010; dmem_delay = 3;
    set_instr(7'h03, 5'd2, 5'd1, 1'b0);
    e = dflt("lw", 8); e.n_dmem = 4; e.rf_we = 1; e.wb_sel = 1; e.b = 1; run(e, 1);

    funct3 = 3'b000; dmem_delay = 0;
    set_instr(7'h63, 5'd0, 5'd1, 1'b1);
    e = dflt("beq taken", 3); e.pc_sel = 1; run(e, 1);
    set_instr(7'h63, 5'd0, 5'd1, 1'b0);
    e = dflt("beq not taken", 3); run(e, 1);

    set_instr(7'h23, 5'd0, 5'd1, 1'b0);
    e = dflt("sw", 4); e.n_dmem = 1; e.dmem_we = 1; e.b = 1; run(e, 1);

    set_instr(7'h6F, 5'd1, 5'd0, 1'b0);
    e = dflt("jal x1", 4); e.rf_we = 1; e.wb_sel = 2; e.pc_sel = 1; e.n_push = 1;
    e.a = 1; e.b = 1; run(e, 1);

    set_instr(7'h67, 5'd0, 5'd1, 1'b0);
    e = dflt("jalr x0,x1", 4); e.wb_sel = 2; e.pc_sel = 2; e.n_pop = 1; e.b = 1; run(e, 1);

    set_instr(7'h67, 5'd5, 5'd1, 1'b0);
    e = dflt("jalr x5,x1", 4); e.rf_we = 1; e.wb_sel = 2; e.pc_sel = 2;
    e.n_push = 1; e.n_pop = 1; e.n_both = 1; e.b = 1; run(e, 1);

    set_instr(7'h67, 5'd1, 5'd1, 1'b0);
    e = dflt("jalr x1,x1", 4); e.rf_we = 1; e.wb_sel = 2; e.pc_sel = 2;
    e.n_push = 1; e.b = 1; run(e, 1);

    set_instr(7'h37, 5'd3, 5'd0, 1'b0);
    e = dflt("lui", 4); e.rf_we = 1; e.wb_sel = 3; e.b = 1; run(e, 1);

    set_instr(7'h17, 5'd4, 5'd0, 1'b0);
    e = dflt("auipc", 4); e.rf_we = 1; e.a = 1; e.b = 1; run(e, 1);

    set_instr(7'h33, 5'd6, 5'd1, 1'b0);
    e = dflt("add", 4); e.rf_we = 1; run(e, 1);

    set_instr(7'h13, 5'd0, 5'd0, 1'b0);
    e = dflt("addi x0", 4); e.b = 1; run(e, 1);

    mem_if.imem_ready = 1'b0;
    e = dflt("fetch timeout", 4); e.pc_we = 0; e.berr = 1; e.n_ir = 0; run(e, 0);
    mem_if.imem_ready = 1'b1;
    set_instr(7'h7F, 5'd0, 5'd0, 1'b0);
    e = dflt("illegal", 3); e.ill = 1; e.b = 1; run(e, 1);

    dmem_delay = 99;
    set_instr(7'h23, 5'd0, 5'd1, 1'b0);
    e = dflt("sw timeout", 7); e.n_dmem = 4; e.dmem_we = 1; e.berr = 1; e.b = 1; run(e, 0);

    dmem_delay = 0;
    set_instr(7'h13, 5'd7, 5'd0, 1'b0);
    e = dflt("addi x7", 4); e.rf_we = 1; e.b = 1; run(e, 1);

    dmem_delay = 99;
    set_instr(7'h03, 5'd2, 5'd1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (mem_if.dmem_req) break;
      @(posedge clk); #1;
    end
    check("dmem_req before reset", mem_if.dmem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("reset drops dmem_req", mem_if.dmem_req, 0);
    check("reset imem_req", mem_if.imem_req, 0);
    check("reset clears instret", instret, 0);
    exp_instret = 0;
    dmem_delay = 0;
    set_instr(7'h13, 5'd1, 5'd0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after release", mem_if.imem_req, 0);
    e = dflt("addi after reset", 4); e.rf_we = 1; e.b = 1; run(e, 1);
    check("instret final", instret, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
